alu_arbiter: RTL and testbench

Shares a single combinational ALU (add/sub/and/or/nor/slt) between two requesters, e.g. the main datapath and an address/branch-compare helper. Each requester issues one operation through a valid/ready handshake. The arbiter latches the winning operands, drives the shared ALU, captures Result/Zero and returns them on that requester's response port. It sits between the requesters and the ALU instance and owns the ALU's A, B and ALUC inputs.

---
 rtl/alu_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// A request is accepted with a valid/ready handshake, its operands are latched,
// the shared ALU is driven from the latched copy for one cycle, and the captured
// Result/Zero are returned on the owner's response port until consumed.
//
// Optional feature macro: ALU_ARB_RR_EN
//   defined   -> round-robin arbitration using a last-grant pointer
//   undefined -> fixed priority, port 0 wins contention (no pointer register)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/_ready         request handshake per port
//   req{0,1}_a/_b/_aluc           request operands and ALU control code
//   rsp{0,1}_valid/_ready         response handshake per port
//   rsp_result, rsp_zero          captured ALU outputs, shared by both ports
//   alu_a, alu_b, alu_aluc        drive the shared ALU
//   alu_result, alu_zero          outputs of the shared ALU
module alu_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  // port 0 request
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [ALUC_W-1:0] req0_aluc,
  // port 1 request
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [ALUC_W-1:0] req1_aluc,
  // responses
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  // shared ALU
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [ALUC_W-1:0] alu_aluc,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [ALUC_W-1:0]   aluc_q, aluc_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                zero_q, zero_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic                grant0, grant1;
  logic                rsp_done;

`ifdef ALU_ARB_RR_EN
  // Records the owner of the last completed operation; reset to 1 so that
  // port 0 wins the first contention.
  logic ptr_q, ptr_d;
`endif

  // Arbitration: purely combinational from the request valids (and pointer).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
`ifdef ALU_ARB_RR_EN
      // Under contention, grant the port that did not win last time.
      grant0 = req0_valid & (~req1_valid | ptr_q);
      grant1 = req1_valid & (~req0_valid | ~ptr_q);
`else
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Response consumed by the current owner.
  assign rsp_done = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    aluc_d       = aluc_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
`ifdef ALU_ARB_RR_EN
    ptr_d        = ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (grant0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          aluc_d  = req0_aluc;
          owner_d = 1'b0;
          state_d = StExec;
        end else if (grant1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          aluc_d  = req1_aluc;
          owner_d = 1'b1;
          state_d = StExec;
        end
      end

      StExec: begin
        // ALU settles on the latched operands during this cycle.
        result_d     = alu_result;
        zero_d       = alu_zero;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = StResp;
      end

      StResp: begin
        if (rsp_done) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
`ifdef ALU_ARB_RR_EN
          ptr_d        = owner_q;
`endif
          state_d      = StIdle;
        end
      end

      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      aluc_q       <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr_q        <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      aluc_q       <= aluc_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_ARB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  // ALU inputs always come from the latched copy so they never follow the
  // live request buses.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_aluc   = aluc_q;

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_aluc, req1_aluc;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_aluc;
  logic        alu_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .ALUC_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Shared ALU stand-in
  always_comb begin
    alu_result = 32'd0;
    case (alu_aluc)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response handshake is seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid && rsp1_valid) begin
        n_cmp++;
        n_err++;
        $display("FAIL both_rsp_valid: got 1 expected 0");
      end
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? (rsp0_valid && rsp0_ready) : (rsp1_valid && rsp1_ready)) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp port %0d: got result %0h expected none", p, rsp_result);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_port", p, e.port);
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents a request, waits (bounded) for acceptance, optionally pushes the
  // expected response. Returns one time unit after the accept edge (EXEC cycle).
  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input bit push, input logic [31:0] er,
                       input logic ez, output int waited);
    exp_t e;
    bit   ok;
    @(posedge clk); #1;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = c;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = c;
    end
    ok = 1'b0;
    waited = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout port %0d: got no ready expected ready", port);
    end else if (push) begin
      e.port = port; e.res = er; e.zero = ez;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  int          waited;
  int          found;
  logic [31:0] exp_grant [4];

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluc = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);

    // Single add on port 0, cycle-accurate latency
    issue(0, 32'd15, 32'd10, 4'b0010, 1'b1, 32'd25, 1'b0, waited);
    chk("add_ready_same_cycle", waited, 32'd0);
    @(negedge clk);
    chk("add_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("add_exec_alu_a", alu_a, 32'd15);
    @(negedge clk);
    chk("add_resp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_resp_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    drain();

    // Port 1: sub to zero, then slt
    issue(1, 32'd10, 32'd10, 4'b0110, 1'b1, 32'd0, 1'b1, waited);
    drain();
    issue(1, 32'd5, 32'd12, 4'b0111, 1'b1, 32'd1, 1'b0, waited);
    drain();

    // Contention from a fresh reset so the pointer starts at 1
    do_reset();
`ifdef ALU_ARB_RR_EN
    exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 0; exp_grant[3] = 1;
`else
    exp_grant[0] = 0; exp_grant[1] = 0; exp_grant[2] = 0; exp_grant[3] = 0;
`endif
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'd12; req0_b = 32'd5; req0_aluc = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd12; req1_b = 32'd5; req1_aluc = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      found = -1;
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        if (req0_ready && req1_ready) found = 2;
        else if (req0_ready) found = 0;
        else if (req1_ready) found = 1;
        if (found >= 0) break;
      end
      chk($sformatf("grant_%0d", k), found, exp_grant[k]);
      if (found == 0 || found == 1) begin
        e.port = found;
        e.res  = (found == 0) ? 32'd4 : 32'd13;
        e.zero = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk);
      if (k == 3) begin
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    drain();

    // Response backpressure on port 0 with port 1 waiting
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    issue(0, 32'd7, 32'd3, 4'b0010, 1'b1, 32'd10, 1'b0, waited);
    req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd3; req1_aluc = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'd10);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_accept", {31'd0, req1_ready}, 32'd1);
    if (req1_ready) begin
      exp_t e;
      e.port = 1; e.res = 32'd2; e.zero = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // Reset in EXEC discards the operation
    issue(1, 32'd3, 32'd4, 4'b0010, 1'b0, 32'd0, 1'b0, waited);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("mid_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", {31'd0, rsp1_valid}, 32'd0);
    end

    // Operand hold: live operand changes after the handshake
    issue(0, 32'd20, 32'd6, 4'b0110, 1'b1, 32'd14, 1'b0, waited);
    req0_a = 32'd99;
    @(negedge clk);
    chk("hold_alu_a", alu_a, 32'd20);
    chk("hold_alu_b", alu_b, 32'd6);
    chk("hold_alu_aluc", {28'd0, alu_aluc}, 32'd6);
    drain();

    // Unknown opcode passes through unchanged
    issue(1, 32'd9, 32'd9, 4'b1111, 1'b1, 32'd0, 1'b1, waited);
    @(negedge clk);
    chk("unk_alu_aluc", {28'd0, alu_aluc}, 32'hF);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
